// File: rtl/mix_columns_engine_if.sv
// Handshake bundle for mix_columns_engine.
//   i_valid/o_ready : upstream block handshake
//   i_block         : input state, column c at [WORD*(NB-c)-1 -: WORD]
//   i_inv/i_bypass  : per-block mode (bypass overrides inv)
//   i_round         : round tag carried with the block
//   o_valid/i_ready : downstream result handshake
//   o_block/o_round : transformed state and its tag
// slave  = engine side, master = producer/consumer side.
interface mix_columns_engine_if #(
    parameter int WORD = 32,
    parameter int NB   = 4
);
    logic                 i_valid;
    logic                 o_ready;
    logic [WORD*NB-1:0]   i_block;
    logic                 i_inv;
    logic                 i_bypass;
    logic [3:0]           i_round;
    logic                 o_valid;
    logic                 i_ready;
    logic [WORD*NB-1:0]   o_block;
    logic [3:0]           o_round;

    modport slave (
        input  i_valid, i_block, i_inv, i_bypass, i_round, i_ready,
        output o_ready, o_valid, o_block, o_round
    );

    modport master (
        output i_valid, i_block, i_inv, i_bypass, i_round, i_ready,
        input  o_ready, o_valid, o_block, o_round
    );
endinterface

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns round stage (between ShiftRows and AddRoundKey).
// Transforms COLS_PER_CYCLE columns per clock; a block takes NB/COLS_PER_CYCLE
// cycles in BUSY, bypass blocks skip straight to DONE. The result is held in
// DONE until the downstream accepts it.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : mix_columns_engine_if.slave (valid/ready in, valid/ready out,
//          block, mode bits, round tag)
module mix_columns_engine #(
    parameter int WORD           = 32,
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mix_columns_engine_if.slave   bus
);

    localparam int G  = NB / COLS_PER_CYCLE;
    localparam int CW = (G > 1) ? $clog2(G) : 1;

    generate
        if (WORD != 32) begin : g_bad_word
            $error("mix_columns_engine: WORD must be 32");
        end
        if (COLS_PER_CYCLE < 1 || (NB % COLS_PER_CYCLE) != 0) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must divide NB");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [WORD*NB-1:0]  work_q;
    logic [WORD*NB-1:0]  res_q;
    logic [WORD*NB-1:0]  next_res;
    logic                inv_q;
    logic [3:0]          round_q;
    logic                valid_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // One column; 04/08 multiples come from chained xtime so the inverse
    // coefficients are pure XOR combinations of 1/2/4/8 multiples.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  s  [4];
        logic [7:0]  m2 [4];
        logic [7:0]  m4 [4];
        logic [7:0]  m8 [4];
        logic [31:0] r;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]  = col[31-8*i -: 8];
            m2[i] = xtime(s[i]);
            m4[i] = xtime(m2[i]);
            m8[i] = xtime(m4[i]);
        end
        r = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (inv) begin
                r[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                               ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ s[(i+1)%4])
                               ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ s[(i+2)%4])
                               ^ (m8[(i+3)%4] ^ s[(i+3)%4]);
            end else begin
                r[31-8*i -: 8] = m2[i]
                               ^ (m2[(i+1)%4] ^ s[(i+1)%4])
                               ^ s[(i+2)%4]
                               ^ s[(i+3)%4];
            end
        end
        return r;
    endfunction

    // Result register with the current column group replaced.
    always_comb begin
        next_res = res_q;
        for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
            int unsigned idx;
            int unsigned pos;
            idx = 32'(cnt_q) * COLS_PER_CYCLE + k;
            pos = WORD * (NB - 1 - idx);
            next_res[pos +: WORD] = mix_col(work_q[pos +: WORD], inv_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            res_q   <= '0;
            inv_q   <= 1'b0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        work_q  <= bus.i_block;
                        inv_q   <= bus.i_inv;
                        round_q <= bus.i_round;
                        cnt_q   <= '0;
                        if (bus.i_bypass) begin
                            res_q   <= bus.i_block;
                            valid_q <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    res_q <= next_res;
                    if (cnt_q == CW'(G - 1)) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_ready = (state_q == S_IDLE);
    assign bus.o_valid = valid_q;
    assign bus.o_block = res_q;
    assign bus.o_round = round_q;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine: CPC=1 instance carries most
// scenarios, CPC=2 and CPC=4 instances share one stimulus set.
module tb_mix_columns_engine;

    localparam logic [127:0] TV1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] TV1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    mix_columns_engine_if #(.WORD(32), .NB(4)) if1 ();
    mix_columns_engine_if #(.WORD(32), .NB(4)) if2 ();
    mix_columns_engine_if #(.WORD(32), .NB(4)) if4 ();

    mix_columns_engine #(.WORD(32), .NB(4), .COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
    mix_columns_engine #(.WORD(32), .NB(4), .COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst), .bus(if2));
    mix_columns_engine #(.WORD(32), .NB(4), .COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst), .bus(if4));

    logic         s_valid, s_inv, s_byp, s_ready;
    logic [127:0] s_block;
    logic [3:0]   s_round;
    assign if2.i_valid = s_valid;  assign if4.i_valid = s_valid;
    assign if2.i_block = s_block;  assign if4.i_block = s_block;
    assign if2.i_inv   = s_inv;    assign if4.i_inv   = s_inv;
    assign if2.i_bypass = s_byp;   assign if4.i_bypass = s_byp;
    assign if2.i_round = s_round;  assign if4.i_round = s_round;
    assign if2.i_ready = s_ready;  assign if4.i_ready = s_ready;

    // Reference: generic GF(2^8) shift-and-add multiply and matrix product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_block(input logic [127:0] blk, input logic inv, input logic byp);
        logic [7:0]   coef [4];
        logic [7:0]   s    [4];
        logic [7:0]   o;
        logic [127:0] r;
        if (byp) return blk;
        if (inv) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = blk;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) s[rr] = blk[127-32*c-8*rr -: 8];
            for (int rr = 0; rr < 4; rr++) begin
                o = 8'h00;
                for (int k = 0; k < 4; k++) o = o ^ gmul(coef[k], s[(rr+k)%4]);
                r[127-32*c-8*rr -: 8] = o;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a block to u1 (call at a negedge); returns rising edges from the
    // accept edge until o_valid is visible. Mode inputs are scrambled while busy.
    task automatic send1(input logic [127:0] blk, input logic inv, input logic byp,
                         input logic [3:0] rnd, output int lat);
        int w;
        w = 0;
        while (if1.o_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        if1.i_valid = 1'b1; if1.i_block = blk; if1.i_inv = inv;
        if1.i_bypass = byp; if1.i_round = rnd;
        @(negedge clk);
        lat = 0;
        while (if1.o_valid !== 1'b1 && lat < 50) begin
            if1.i_valid  = 1'($urandom);
            if1.i_inv    = 1'($urandom);
            if1.i_bypass = 1'($urandom);
            if1.i_block  = rand_block();
            @(negedge clk);
            lat++;
        end
        if1.i_valid = 1'b0;
    endtask

    task automatic release1(input string name);
        if1.i_ready = 1'b1;
        @(negedge clk);
        if1.i_ready = 1'b0;
        checks++;
        if (if1.o_valid !== 1'b0 || if1.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: o_valid=%b o_ready=%b expected 0/1", name, if1.o_valid, if1.o_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        if1.i_valid = 1'b1; if1.i_block = rand_block(); s_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (if1.o_ready !== 1'b1 || if1.o_valid !== 1'b0 || if1.o_block !== '0 || if1.o_round !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b blk=%h rnd=%h expected 1/0/0/0",
                     if1.o_ready, if1.o_valid, if1.o_block, if1.o_round);
        end
        checks++;
        if (if2.o_ready !== 1'b1 || if4.o_ready !== 1'b1 || if2.o_valid !== 1'b0 || if4.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_cpc: rdy2=%b rdy4=%b vld2=%b vld4=%b expected 1/1/0/0",
                     if2.o_ready, if4.o_ready, if2.o_valid, if4.o_valid);
        end
        if1.i_valid = 1'b0; s_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        int lat;
        send1(TV1_IN, 1'b0, 1'b0, 4'h3, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL fwd_latency: got %0d expected 4", lat); end
        checks++;
        if (if1.o_block !== TV1_OUT) begin errors++; $display("FAIL fwd_block: got %h expected %h", if1.o_block, TV1_OUT); end
        checks++;
        if (if1.o_round !== 4'h3) begin errors++; $display("FAIL fwd_round: got %h expected 3", if1.o_round); end
        release1("fwd");
    endtask

    task automatic test_inverse();
        int lat;
        send1(TV1_OUT, 1'b1, 1'b0, 4'h5, lat);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL inv_latency: got %0d expected 4", lat); end
        checks++;
        if (if1.o_block !== TV1_IN) begin errors++; $display("FAIL inv_block: got %h expected %h", if1.o_block, TV1_IN); end
        release1("inv");
    endtask

    task automatic test_bypass();
        int lat;
        logic [127:0] blk;
        blk = {64'hd4d4d4d5_2d26314c, $urandom, $urandom};
        send1(blk, 1'b1, 1'b1, 4'hA, lat);
        checks++;
        if (lat != 0) begin errors++; $display("FAIL byp_latency: extra edges %0d expected 0 after accept", lat); end
        checks++;
        if (if1.o_block !== blk) begin errors++; $display("FAIL byp_block: got %h expected %h", if1.o_block, blk); end
        checks++;
        if (if1.o_round !== 4'hA) begin errors++; $display("FAIL byp_round: got %h expected a", if1.o_round); end
        release1("byp");
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] blk, exp;
        blk = {64'hd4d4d4d5_2d26314c, $urandom, $urandom};
        exp = ref_block(blk, 1'b0, 1'b0);
        send1(blk, 1'b0, 1'b0, 4'h6, lat);
        checks++;
        if (if1.o_block[127:96] !== 32'hd5d5d7d6) begin
            errors++; $display("FAIL bp_col0_vector: got %h expected d5d5d7d6", if1.o_block[127:96]);
        end
        for (int i = 0; i < 10; i++) begin
            if1.i_valid = 1'($urandom);
            if1.i_block = rand_block();
            if1.i_inv   = 1'($urandom);
            checks++;
            if (if1.o_block[127:64] !== exp[127:64] || if1.o_ready !== 1'b0 || if1.o_valid !== 1'b1 || if1.o_round !== 4'h6) begin
                errors++;
                $display("FAIL bp_hold: cyc=%0d blk=%h rdy=%b vld=%b expected %h/0/1",
                         i, if1.o_block[127:64], if1.o_ready, if1.o_valid, exp[127:64]);
            end
            @(negedge clk);
        end
        if1.i_valid = 1'b0;
        release1("bp");
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        logic [127:0] blk;
        if1.i_valid = 1'b1; if1.i_block = TV1_IN; if1.i_inv = 1'b0; if1.i_bypass = 1'b0; if1.i_round = 4'hF;
        @(negedge clk);
        if1.i_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (if1.o_valid !== 1'b0 || if1.o_block !== '0 || if1.o_ready !== 1'b1 || if1.o_round !== 4'h0) begin
            errors++;
            $display("FAIL kill_state: vld=%b blk=%h rdy=%b rnd=%h expected 0/0/1/0",
                     if1.o_valid, if1.o_block, if1.o_ready, if1.o_round);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        blk = rand_block();
        send1(blk, 1'b0, 1'b0, 4'h7, lat);
        checks++;
        if (if1.o_block !== ref_block(blk, 1'b0, 1'b0) || lat != 4 || if1.o_round !== 4'h7) begin
            errors++;
            $display("FAIL kill_next: got %h lat=%0d expected %h lat=4",
                     if1.o_block, lat, ref_block(blk, 1'b0, 1'b0));
        end
        release1("kill");
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] blk, exp;
        logic inv, byp;
        logic [3:0] rnd;
        for (int i = 0; i < 20; i++) begin
            blk = rand_block(); inv = 1'($urandom); byp = ($urandom_range(0, 3) == 0); rnd = 4'($urandom);
            exp = ref_block(blk, inv, byp);
            send1(blk, inv, byp, rnd, lat);
            checks++;
            if (if1.o_block !== exp || if1.o_round !== rnd || lat != (byp ? 0 : 4)) begin
                errors++;
                $display("FAIL rand_%0d: got %h/%h lat=%0d expected %h/%h lat=%0d (inv=%b byp=%b)",
                         i, if1.o_block, if1.o_round, lat, exp, rnd, byp ? 0 : 4, inv, byp);
            end
            release1("rand");
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] qb[$];
        logic [3:0]   qr[$];
        logic [127:0] eb;
        logic [3:0]   er;
        int last_acc, nres;
        last_acc = -1; nres = 0;
        if1.i_ready = 1'b1; if1.i_valid = 1'b1; if1.i_bypass = 1'b0;
        if1.i_block = rand_block(); if1.i_inv = 1'($urandom); if1.i_round = 4'($urandom);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (if1.o_valid === 1'b1) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: result %h with nothing outstanding", if1.o_block);
                end else begin
                    eb = qb.pop_front(); er = qr.pop_front();
                    if (if1.o_block !== eb || if1.o_round !== er) begin
                        errors++; $display("FAIL b2b_result: got %h/%h expected %h/%h", if1.o_block, if1.o_round, eb, er);
                    end
                end
                nres++;
            end
            if (if1.o_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++; $display("FAIL b2b_period: got %0d expected 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                qb.push_back(ref_block(if1.i_block, if1.i_inv, 1'b0));
                qr.push_back(if1.i_round);
            end else begin
                if1.i_block = rand_block(); if1.i_inv = 1'($urandom); if1.i_round = 4'($urandom);
            end
            @(negedge clk);
        end
        if1.i_valid = 1'b0;
        for (int w = 0; w < 20 && qb.size() > 0; w++) begin
            if (if1.o_valid === 1'b1) begin
                eb = qb.pop_front(); er = qr.pop_front();
                checks++;
                if (if1.o_block !== eb || if1.o_round !== er) begin
                    errors++; $display("FAIL b2b_drain: got %h expected %h", if1.o_block, eb);
                end
                nres++;
            end
            @(negedge clk);
        end
        if1.i_ready = 1'b0;
        checks++;
        if (qb.size() != 0 || nres < 9) begin
            errors++; $display("FAIL b2b_count: outstanding=%0d results=%0d expected 0 and >=9", qb.size(), nres);
        end
        @(negedge clk);
    endtask

    task automatic test_cpc_variants();
        int lat2, lat4;
        logic [127:0] blk, exp;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                blk = TV1_IN; s_inv = 1'b0; s_byp = 1'b0; s_round = 4'h9;
            end else begin
                blk = rand_block(); s_inv = 1'($urandom); s_byp = 1'b0; s_round = 4'($urandom);
            end
            exp = ref_block(blk, s_inv, 1'b0);
            s_block = blk; s_valid = 1'b1; s_ready = 1'b0;
            @(negedge clk);
            s_valid = 1'b0;
            lat2 = -1; lat4 = -1;
            for (int n = 0; n < 10; n++) begin
                if (if2.o_valid === 1'b1 && lat2 < 0) lat2 = n;
                if (if4.o_valid === 1'b1 && lat4 < 0) lat4 = n;
                s_inv = 1'($urandom);
                @(negedge clk);
            end
            checks++;
            if (lat2 != 2 || lat4 != 1) begin
                errors++; $display("FAIL cpc_latency_%0d: cpc2=%0d cpc4=%0d expected 2/1", i, lat2, lat4);
            end
            checks++;
            if (if2.o_block !== exp || if4.o_block !== exp || if2.o_round !== s_round || if4.o_round !== s_round) begin
                errors++; $display("FAIL cpc_block_%0d: cpc2=%h cpc4=%h expected %h", i, if2.o_block, if4.o_block, exp);
            end
            if (i == 0) begin
                checks++;
                if (if4.o_block !== TV1_OUT) begin
                    errors++; $display("FAIL cpc4_vector: got %h expected %h", if4.o_block, TV1_OUT);
                end
            end
            s_ready = 1'b1;
            @(negedge clk);
            s_ready = 1'b0;
            checks++;
            if (if2.o_ready !== 1'b1 || if4.o_ready !== 1'b1 || if2.o_valid !== 1'b0 || if4.o_valid !== 1'b0) begin
                errors++; $display("FAIL cpc_release_%0d: rdy=%b%b vld=%b%b expected 11/00",
                                   i, if2.o_ready, if4.o_ready, if2.o_valid, if4.o_valid);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        if1.i_valid = 1'b0; if1.i_block = '0; if1.i_inv = 1'b0; if1.i_bypass = 1'b0;
        if1.i_round = '0; if1.i_ready = 1'b0;
        s_valid = 1'b0; s_block = '0; s_inv = 1'b0; s_byp = 1'b0; s_round = '0; s_ready = 1'b0;
        test_reset();
        test_forward();
        test_inverse();
        test_bypass();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        test_cpc_variants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
